load_store_sequencer: RTL and testbench

Command-driven controller that sequences a bank of NREGS parallel-in/parallel-out byte registers for the load/store machine. It accepts load, store and clear commands over a valid/ready interface. It drives every register's read_en, write_en and input-select so that unaddressed registers hold their value. Load results return on a valid/ready response channel.

---
 rtl/load_store_sequencer.sv | 128 ++++++++++++
 tb/tb_load_store_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_sequencer.sv
// Sequencer for a bank of byte registers: accepts load/store/clear commands and
// drives per-register gates so that registers not being addressed keep their value.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a command; every register holds
// S_STORE | addressed register takes bus_data at the end of the cycle
// S_CLEAR | addressed register input gated off, so it captures 0
// S_LOAD  | addressed register output captured into rsp_data
// S_RESP  | response offered until rsp_ready
module load_store_sequencer #(
  parameter int NREGS  = 4,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic [NREGS-1:0]       reg_read_en,
  output logic [NREGS-1:0]       reg_write_en,
  output logic [NREGS-1:0]       reg_din_sel,
  output logic [WIDTH-1:0]       bus_data,
  input  logic [NREGS*WIDTH-1:0] reg_q,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_CLEAR,
    S_LOAD,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    rsp_data_q;
  logic                rsp_err_q;
  logic [NREGS-1:0]    addr_dec;
  logic [WIDTH-1:0]    load_slice;

  assign addr_dec = NREGS'(1) << addr_q;

  always_comb begin
    load_slice = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_q == ADDR_W'(i)) load_slice = reg_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            data_q     <= cmd_data;
            rsp_data_q <= '0;
            rsp_err_q  <= (cmd_op == 2'b11);
          end
        end
        S_LOAD:  rsp_data_q <= load_slice;
        default: ;
      endcase
    end
  end

  // Every register defaults to the hold encoding; only the addressed one is overridden.
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    reg_read_en  = '1;
    reg_write_en = '1;
    reg_din_sel  = '0;
    bus_data     = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'b00:   state_nxt = S_LOAD;
            2'b01:   state_nxt = S_STORE;
            2'b10:   state_nxt = S_CLEAR;
            default: state_nxt = S_RESP;
          endcase
        end
      end
      S_STORE: begin
        reg_din_sel = addr_dec;
        bus_data    = data_q;
        state_nxt   = S_RESP;
      end
      S_CLEAR: begin
        reg_read_en = ~addr_dec;
        state_nxt   = S_RESP;
      end
      S_LOAD: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = ~cmd_ready;
  assign rsp_data = rsp_valid ? rsp_data_q : '0;
  assign rsp_err  = rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: a gated register bank around the DUT, a
// vector table, directed stall/reset sequences and randomized commands.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  reg_read_en;
  logic [3:0]  reg_write_en;
  logic [3:0]  reg_din_sel;
  logic [7:0]  bus_data;
  logic [31:0] reg_q;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bank [4];
  logic [7:0] mem  [4];

  always #5 clk = ~clk;

  load_store_sequencer dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en), .reg_din_sel(reg_din_sel),
    .bus_data(bus_data), .reg_q(reg_q), .busy(busy)
  );

  // External register bank: input gate, input select, output gate, own clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!reg_read_en[i])    bank[i] <= 8'h00;
        else if (reg_din_sel[i]) bank[i] <= bus_data;
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < 4; i++) reg_q[i*8 +: 8] = reg_write_en[i] ? bank[i] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                        input int stall, input logic [7:0] exp_d, input logic exp_e);
    int lat;
    logic [3:0] onehot;
    onehot = 4'b0001 << a;
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 8'($urandom);
    @(negedge clk);
    lat = 1;
    check("busy_after_accept", {31'd0, busy}, 1);
    check("write_en", {28'd0, reg_write_en}, 32'hF);
    case (op)
      2'b01: begin
        check("store_din_sel", {28'd0, reg_din_sel}, {28'd0, onehot});
        check("store_read_en", {28'd0, reg_read_en}, 32'hF);
        check("store_bus", {24'd0, bus_data}, {24'd0, d});
      end
      2'b10: begin
        check("clear_read_en", {28'd0, reg_read_en}, {28'd0, ~onehot});
        check("clear_din_sel", {28'd0, reg_din_sel}, 0);
        check("clear_bus", {24'd0, bus_data}, 0);
      end
      default: begin
        check("hold_read_en", {28'd0, reg_read_en}, 32'hF);
        check("hold_din_sel", {28'd0, reg_din_sel}, 0);
        check("hold_bus", {24'd0, bus_data}, 0);
      end
    endcase
    while (!rsp_valid && lat < 6) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("latency", lat, (op == 2'b11) ? 1 : 2);
    check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_d});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_e});
    check("cmd_ready_resp", {31'd0, cmd_ready}, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 1);
      check("stall_data", {24'd0, rsp_data}, {24'd0, exp_d});
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rsp_valid_drop", {31'd0, rsp_valid}, 0);
    check("cmd_ready_back", {31'd0, cmd_ready}, 1);
    check("rsp_data_idle", {24'd0, rsp_data}, 0);
    rsp_ready = 1'b0;
  endtask

  // Reference: an array of register contents updated by the command rules.
  task automatic model_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                           output logic [7:0] exp_d, output logic exp_e);
    exp_d = 8'h00;
    exp_e = 1'b0;
    case (op)
      2'b00: exp_d = mem[a];
      2'b01: mem[a] = d;
      2'b10: mem[a] = 8'h00;
      default: exp_e = 1'b1;
    endcase
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
    int         idle;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [7:0] md;
    logic       me;
    int         seen;

    tbl[0]  = '{2'b01, 2'd2, 8'hA5, 0,  8'h00, 1'b0};
    tbl[1]  = '{2'b00, 2'd2, 8'h00, 2,  8'hA5, 1'b0};
    tbl[2]  = '{2'b01, 2'd0, 8'h11, 0,  8'h00, 1'b0};
    tbl[3]  = '{2'b01, 2'd1, 8'h22, 0,  8'h00, 1'b0};
    tbl[4]  = '{2'b01, 2'd2, 8'h33, 0,  8'h00, 1'b0};
    tbl[5]  = '{2'b01, 2'd3, 8'h44, 0,  8'h00, 1'b0};
    tbl[6]  = '{2'b00, 2'd0, 8'h00, 20, 8'h11, 1'b0};
    tbl[7]  = '{2'b00, 2'd1, 8'h00, 0,  8'h22, 1'b0};
    tbl[8]  = '{2'b00, 2'd2, 8'h00, 0,  8'h33, 1'b0};
    tbl[9]  = '{2'b00, 2'd3, 8'h00, 0,  8'h44, 1'b0};
    tbl[10] = '{2'b10, 2'd1, 8'hEE, 0,  8'h00, 1'b0};
    tbl[11] = '{2'b00, 2'd0, 8'h00, 0,  8'h11, 1'b0};
    tbl[12] = '{2'b00, 2'd1, 8'h00, 0,  8'h00, 1'b0};
    tbl[13] = '{2'b00, 2'd2, 8'h00, 0,  8'h33, 1'b0};
    tbl[14] = '{2'b00, 2'd3, 8'h00, 0,  8'h44, 1'b0};
    tbl[15] = '{2'b11, 2'd2, 8'h9C, 0,  8'h00, 1'b1};
    tbl[16] = '{2'b00, 2'd2, 8'h00, 0,  8'h33, 1'b0};
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // Reset values while clr is held low
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_bus", {24'd0, bus_data}, 0);
    check("rst_rsp_data", {24'd0, rsp_data}, 0);
    check("rst_rsp_err", {31'd0, rsp_err}, 0);
    check("rst_read_en", {28'd0, reg_read_en}, 32'hF);
    check("rst_write_en", {28'd0, reg_write_en}, 32'hF);
    check("rst_din_sel", {28'd0, reg_din_sel}, 0);
    clr = 1'b1;

    for (int i = 0; i < 17; i++) begin
      repeat (tbl[i].idle) @(negedge clk);
      do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, 0, tbl[i].exp_d, tbl[i].exp_e);
      model_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, md, me);
    end

    // Stalled response: data stays stable and a command pulse is ignored
    do_cmd(2'b01, 2'd0, 8'h5A, 0, 8'h00, 1'b0);
    model_cmd(2'b01, 2'd0, 8'h5A, md, me);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 2'd0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 6 && !rsp_valid; k++) begin
      @(negedge clk);
      seen = k + 1;
    end
    check("stall_rsp_seen", {31'd0, rsp_valid}, 1);
    check("stall_latency", seen, 2);
    for (int k = 0; k < 5; k++) begin
      check("stall5_valid", {31'd0, rsp_valid}, 1);
      check("stall5_data", {24'd0, rsp_data}, 32'h5A);
      check("stall5_cmd_ready", {31'd0, cmd_ready}, 0);
      cmd_valid = (k == 1);
      cmd_op = 2'b01; cmd_addr = 2'd0; cmd_data = 8'h77;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("stall_release", {31'd0, rsp_valid}, 0);
    rsp_ready = 1'b0;
    do_cmd(2'b00, 2'd0, 8'h00, 0, 8'h5A, 1'b0);

    // Reset in the middle of a store
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 2'd3; cmd_data = 8'hFF; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("midrst_bus_before", {24'd0, bus_data}, 32'hFF);
    #2 clr = 1'b0;
    #1;
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_bus", {24'd0, bus_data}, 0);
    @(negedge clk);
    clr = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    do_cmd(2'b00, 2'd3, 8'h00, 0, 8'h00, 1'b0);

    // Randomized commands against the reference array
    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [1:0] a;
      logic [7:0] d;
      int         st;
      op = 2'($urandom_range(0, 3));
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      st = $urandom_range(0, 3);
      model_cmd(op, a, d, md, me);
      do_cmd(op, a, d, st, md, me);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
